// File: rtl/mem_arbiter_if.sv
// Cache-pair / RAM bus bundle for the memory arbiter.
// master = arbiter side, slave = caches plus RAM model.
interface mem_arbiter_if #(
    parameter int WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache: data priority with a starvation override.
// Optional ARB_STATS_EN adds igrant_cnt/dgrant_cnt/conflict_cnt statistics outputs.
module mem_arbiter #(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    mem_arbiter_if.master     bus
`ifdef ARB_STATS_EN
    ,
    output logic [WORD_W-1:0] igrant_cnt,
    output logic [WORD_W-1:0] dgrant_cnt,
    output logic [WORD_W-1:0] conflict_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IGNT = 2'd1;
    localparam logic [1:0] DGNT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;

    logic access;
    logic d_req;
    logic starved;
    logic i_done;
    logic d_done;

    assign access  = (bus.ramstate == RAM_ACCESS);
    assign d_req   = bus.dREN | bus.dWEN;
    assign starved = (STARVE_LIMIT != 0) && (starve_cnt_reg == LIMIT);
    assign i_done  = (state_reg == IGNT) && access;
    assign d_done  = (state_reg == DGNT) && access;

    // RAM strobes follow the granted request live, so a withdrawn request drops them at once.
    always_comb begin
        state_next   = state_reg;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state_reg)
            IDLE: begin
                if (bus.iREN && starved)
                    state_next = IGNT;
                else if (d_req)
                    state_next = DGNT;
                else if (bus.iREN)
                    state_next = IGNT;
            end
            IGNT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                if (access) begin
                    bus.iwait  = 1'b0;
                    bus.iload  = bus.ramload;
                    state_next = IDLE;
                end else if (!bus.iREN) begin
                    state_next = IDLE;
                end
            end
            DGNT: begin
                bus.ramREN   = bus.dREN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (access) begin
                    bus.dwait  = 1'b0;
                    bus.dload  = bus.dWEN ? '0 : bus.ramload;
                    state_next = IDLE;
                end else if (!d_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counts data completions the fetch side has sat through; any idle fetch cycle forgives it.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!bus.iREN || i_done)
            starve_cnt_next = '0;
        else if (d_done && (starve_cnt_reg != LIMIT))
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

`ifdef ARB_STATS_EN
    logic conflict;
    assign conflict = (state_reg == IDLE) && bus.iREN && d_req;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            igrant_cnt   <= '0;
            dgrant_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (i_done)
                igrant_cnt <= igrant_cnt + WORD_W'(1);
            if (d_done)
                dgrant_cnt <= dgrant_cnt + WORD_W'(1);
            if (conflict)
                conflict_cnt <= conflict_cnt + WORD_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences, randomized model.
module tb_mem_arbiter;

    localparam int W   = 32;
    localparam int LIM = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.WORD_W(W)) bus ();

`ifdef ARB_STATS_EN
    logic [W-1:0] igrant_cnt, dgrant_cnt, conflict_cnt;
`endif

    mem_arbiter #(.WORD_W(W), .STARVE_LIMIT(LIM)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
`ifdef ARB_STATS_EN
        ,
        .igrant_cnt   (igrant_cnt),
        .dgrant_cnt   (dgrant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        iren, dren, dwen;
        logic [1:0]  rs;
        logic [31:0] iaddr, daddr, dstore, rload;
        logic        e_iwait, e_dwait, e_ren, e_wen;
        logic [31:0] e_iload, e_dload, e_addr, e_store;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic iren, dren, dwen, input logic [1:0] rs,
                                input logic [31:0] ia, da, ds, rl,
                                input logic e_iw, e_dw, e_ren, e_wen,
                                input logic [31:0] e_il, e_dl, e_a, e_s);
        vec_t v;
        v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs;
        v.iaddr = ia; v.daddr = da; v.dstore = ds; v.rload = rl;
        v.e_iwait = e_iw; v.e_dwait = e_dw; v.e_ren = e_ren; v.e_wen = e_wen;
        v.e_iload = e_il; v.e_dload = e_dl; v.e_addr = e_a; v.e_store = e_s;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iren, dren, dwen, input logic [1:0] rs,
                         input logic [31:0] ia, da, ds, rl);
        bus.iREN = iren; bus.dREN = dren; bus.dWEN = dwen; bus.ramstate = rs;
        bus.iaddr = ia; bus.daddr = da; bus.dstore = ds; bus.ramload = rl;
    endtask

    task automatic check_outs(input string tag, input logic e_iw, e_dw, e_ren, e_wen,
                              input logic [31:0] e_il, e_dl, e_a, e_s);
        chk({tag, ".iwait"},  bus.iwait,  e_iw);
        chk({tag, ".dwait"},  bus.dwait,  e_dw);
        chk({tag, ".iload"},  bus.iload,  e_il);
        chk({tag, ".dload"},  bus.dload,  e_dl);
        chk({tag, ".ramREN"}, bus.ramREN, e_ren);
        chk({tag, ".ramWEN"}, bus.ramWEN, e_wen);
        if (e_ren || e_wen) begin
            chk({tag, ".ramaddr"},  bus.ramaddr,  e_a);
            chk({tag, ".ramstore"}, bus.ramstore, e_s);
        end
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        nRST = 1'b0;
        drive(0, 0, 0, FREE, 0, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Reference model state: who holds the RAM (0 none, 1 fetch, 2 data) and starvation tally.
    int m_owner, m_starve, m_ic, m_dc, m_cc;

    initial begin
        byte   seq[$];
        string exp_seq;
        logic  check_starve_next;
        logic  r_iren, r_dren, r_dwen;
        logic [1:0]  r_rs;
        logic [31:0] r_ia, r_da, r_ds, r_rl;

        // Directed cycle-by-cycle scenario starting from IDLE after reset.
        vecs[0]  = mk(1,0,0,FREE, 32'h40,0,0,0,                         1,1,0,0, 0,0,0,0);
        vecs[1]  = mk(1,0,0,BUSY, 32'h40,0,0,0,                         1,1,1,0, 0,0,32'h40,0);
        vecs[2]  = mk(1,0,0,BUSY, 32'h40,0,0,0,                         1,1,1,0, 0,0,32'h40,0);
        vecs[3]  = mk(1,0,0,ACC,  32'h40,0,0,32'hDEADBEEF,              0,1,1,0, 32'hDEADBEEF,0,32'h40,0);
        vecs[4]  = mk(0,0,0,FREE, 32'h40,0,0,32'hDEADBEEF,              1,1,0,0, 0,0,0,0);
        vecs[5]  = mk(1,0,1,FREE, 32'h44,32'h80,32'h12345678,0,         1,1,0,0, 0,0,0,0);
        vecs[6]  = mk(1,0,1,ACC,  32'h44,32'h80,32'h12345678,32'hAAAA5555, 1,0,0,1, 0,0,32'h80,32'h12345678);
        vecs[7]  = mk(1,0,0,FREE, 32'h44,0,0,0,                         1,1,0,0, 0,0,0,0);
        vecs[8]  = mk(1,0,0,ACC,  32'h44,0,0,32'h11112222,              0,1,1,0, 32'h11112222,0,32'h44,0);
        vecs[9]  = mk(0,0,0,FREE, 0,0,0,0,                              1,1,0,0, 0,0,0,0);
        vecs[10] = mk(0,1,0,FREE, 0,32'h100,32'h77,0,                   1,1,0,0, 0,0,0,0);
        vecs[11] = mk(0,1,0,BUSY, 0,32'h100,32'h77,32'h99,              1,1,1,0, 0,0,32'h100,32'h77);
        vecs[12] = mk(0,0,0,BUSY, 0,32'h100,32'h77,32'h99,              1,1,0,0, 0,0,0,0);
        vecs[13] = mk(0,0,0,FREE, 0,0,0,0,                              1,1,0,0, 0,0,0,0);
        vecs[14] = mk(0,1,0,FREE, 0,32'h104,0,0,                        1,1,0,0, 0,0,0,0);
        vecs[15] = mk(0,1,0,ERR,  0,32'h104,0,32'h33,                   1,1,1,0, 0,0,32'h104,0);
        vecs[16] = mk(0,1,0,ACC,  0,32'h104,0,32'hCAFEF00D,             1,0,1,0, 0,32'hCAFEF00D,32'h104,0);
        vecs[17] = mk(0,0,0,FREE, 0,0,0,0,                              1,1,0,0, 0,0,0,0);
        vecs[18] = mk(1,0,0,FREE, 32'h48,0,0,0,                         1,1,0,0, 0,0,0,0);
        vecs[19] = mk(0,0,0,ACC,  32'h48,0,0,32'h5555AAAA,              0,1,0,0, 32'h5555AAAA,0,0,0);
        vecs[20] = mk(0,0,0,FREE, 0,0,0,0,                              1,1,0,0, 0,0,0,0);

        // Reset state, with requests already raised to show they are ignored.
        drive(1, 1, 0, ACC, 32'h40, 32'h80, 32'h1234, 32'hFFFF0000);
        #2;
        check_outs("reset", 1, 1, 0, 0, 0, 0, 0, 0);
        chk("reset.ramaddr",  bus.ramaddr,  0);
        chk("reset.ramstore", bus.ramstore, 0);
        chk("reset.starve",   dut.starve_cnt_reg, 0);
        @(negedge CLK);
        drive(0, 0, 0, FREE, 0, 0, 0, 0);
        nRST = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge CLK);
            drive(vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].rs,
                  vecs[i].iaddr, vecs[i].daddr, vecs[i].dstore, vecs[i].rload);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_iwait, vecs[i].e_dwait,
                       vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_iload, vecs[i].e_dload,
                       vecs[i].e_addr, vecs[i].e_store);
            $display("vec %0d: iREN=%b dREN=%b dWEN=%b ramstate=%0d -> iwait=%b dwait=%b ramREN=%b ramWEN=%b ramaddr=%h",
                     i, vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].rs,
                     bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ramaddr);
        end

        // Starvation: fetch and data both held, RAM always ready.
        check_starve_next = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            drive(1, 1, 0, ACC, 32'h400, 32'h800, 0, 32'h1000 + c);
            #1;
            if (check_starve_next) begin
                chk("starve.cleared_after_fetch", dut.starve_cnt_reg, 0);
                check_starve_next = 1'b0;
            end
            if (!bus.dwait) seq.push_back("D");
            if (!bus.iwait) begin
                seq.push_back("I");
                check_starve_next = 1'b1;
            end
            if (!bus.dwait || !bus.iwait)
                $display("starve: completion %0d side=%s", seq.size(), bus.dwait ? "I" : "D");
            if (seq.size() >= 6) break;
        end
        exp_seq = "DDDDID";
        chk("starve.completions", seq.size(), 6);
        for (int k = 0; k < 6 && k < seq.size(); k++)
            chk($sformatf("starve.order%0d", k), seq[k], exp_seq[k]);

        // Reset asserted in the middle of a BUSY fetch grant.
        @(negedge CLK);
        drive(1, 0, 0, BUSY, 32'h200, 0, 0, 0);
        @(negedge CLK);
        #1;
        chk("midrst.pre_ramREN", bus.ramREN, 1);
        chk("midrst.pre_starve", dut.starve_cnt_reg, 1);
        nRST = 1'b0;
        #1;
        chk("midrst.iwait",  bus.iwait,  1);
        chk("midrst.ramREN", bus.ramREN, 0);
        chk("midrst.starve", dut.starve_cnt_reg, 0);
        $display("midrst: reset applied during fetch grant, ramREN=%b iwait=%b", bus.ramREN, bus.iwait);
        @(negedge CLK);
        nRST = 1'b1;
        bus.ramstate = ACC;
        bus.ramload  = 32'h0BADCAFE;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            #1;
            if (!bus.iwait) break;
        end
        chk("midrst.fresh_iwait", bus.iwait,   0);
        chk("midrst.fresh_iload", bus.iload,   32'h0BADCAFE);
        chk("midrst.fresh_addr",  bus.ramaddr, 32'h200);
        $display("midrst: fresh fetch iwait=%b iload=%h", bus.iwait, bus.iload);

`ifdef ARB_STATS_EN
        pulse_reset();
        begin
            logic [1:0] reqs[11];
            reqs = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
            for (int k = 0; k < 11; k++) begin
                drive(reqs[k][1], reqs[k][0], 0, ACC, 32'h10 + k, 32'h20 + k, 0, 32'h30 + k);
                @(negedge CLK);
            end
            #1;
            chk("stats.dgrant",   dgrant_cnt,   3);
            chk("stats.igrant",   igrant_cnt,   2);
            chk("stats.conflict", conflict_cnt, 1);
            $display("stats: igrant=%0d dgrant=%0d conflict=%0d", igrant_cnt, dgrant_cnt, conflict_cnt);
        end
`endif

        // Randomized traffic against the behavioural model.
        pulse_reset();
        m_owner = 0; m_starve = 0; m_ic = 0; m_dc = 0; m_cc = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic e_iw, e_dw, e_ren, e_wen, acc, dreq, i_done, d_done;
            logic [31:0] e_il, e_dl, e_a, e_s;
            int nxt, rr, sel;
            @(negedge CLK);
            r_iren = ($urandom_range(0, 99) < 55);
            sel    = $urandom_range(0, 2);
            r_dren = (sel == 1);
            r_dwen = (sel == 2);
            rr     = $urandom_range(0, 9);
            r_rs   = (rr < 4) ? ACC : (rr < 7) ? BUSY : (rr < 9) ? FREE : ERR;
            r_ia = $urandom; r_da = $urandom; r_ds = $urandom; r_rl = $urandom;
            drive(r_iren, r_dren, r_dwen, r_rs, r_ia, r_da, r_ds, r_rl);
            #1;
            e_iw = 1; e_dw = 1; e_ren = 0; e_wen = 0;
            e_il = 0; e_dl = 0; e_a = 0; e_s = 0;
            acc = (r_rs == ACC); dreq = r_dren | r_dwen;
            i_done = 0; d_done = 0; nxt = m_owner;
            if (m_owner == 0) begin
                if (r_iren && dreq) m_cc++;
                if (r_iren && LIM != 0 && m_starve == LIM) nxt = 1;
                else if (dreq) nxt = 2;
                else if (r_iren) nxt = 1;
            end else if (m_owner == 1) begin
                e_ren = r_iren; e_a = r_ia;
                if (acc) begin e_iw = 0; e_il = r_rl; i_done = 1; end
                if (acc || !r_iren) nxt = 0;
            end else begin
                e_ren = r_dren; e_wen = r_dwen; e_a = r_da; e_s = r_ds;
                if (acc) begin e_dw = 0; e_dl = r_dwen ? 32'h0 : r_rl; d_done = 1; end
                if (acc || !dreq) nxt = 0;
            end
            chk("rand.starve", dut.starve_cnt_reg, m_starve);
            check_outs($sformatf("rand%0d", cyc), e_iw, e_dw, e_ren, e_wen, e_il, e_dl, e_a, e_s);
            if (i_done) $display("rand %0d: fetch done addr=%h load=%h", cyc, r_ia, bus.iload);
            if (d_done) $display("rand %0d: data %s done addr=%h load=%h", cyc, r_dwen ? "write" : "read", r_da, bus.dload);
            if (!r_iren || i_done) m_starve = 0;
            else if (d_done && m_starve < LIM) m_starve++;
            if (i_done) m_ic++;
            if (d_done) m_dc++;
            m_owner = nxt;
        end
`ifdef ARB_STATS_EN
        @(negedge CLK);
        #1;
        chk("rand.igrant",   igrant_cnt,   m_ic);
        chk("rand.dgrant",   dgrant_cnt,   m_dc);
        chk("rand.conflict", conflict_cnt, m_cc);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
